// File: rtl/calc_pkg.sv
// Shared types for the calculator control FSM and the execution stage.
// Ports: none (package only).
// Contents: ms_t mode encoding, alu_state_t execution-stage states, legal-opcode helper.
package calc_pkg;

  typedef enum logic [2:0] {
    MS_NONE = 3'd0,
    MS_ADD  = 3'd1,
    MS_SUB  = 3'd2,
    MS_MUL  = 3'd3,
    MS_XOR  = 3'd4
  } ms_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } alu_state_t;

  // True for modes the execution stage can compute; everything else raises err.
  function automatic logic ms_is_legal(input logic [2:0] ms);
    return (ms == MS_ADD) || (ms == MS_SUB) || (ms == MS_MUL) || (ms == MS_XOR);
  endfunction

endpackage

// File: rtl/calc_mul_seq.sv
// Purpose: unsigned WIDTH x WIDTH shift-add multiplier, one multiplier bit per cycle.
// Latency: load on cycle 0, done pulses (one cycle) after WIDTH iterations; prod is then stable.
// Backpressure: none; a new load restarts the multiply unconditionally.
// Ports: CLK, clear_n (async active-low), load, A, B -> prod[2*WIDTH-1:0], done.
module calc_mul_seq #(
  parameter int WIDTH = 4
) (
  input  logic               CLK,
  input  logic               clear_n,
  input  logic               load,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] prod,
  output logic               done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] mcand_q;  // multiplicand, shifted left each iteration
  logic [WIDTH-1:0]   mplier_q; // multiplier, shifted right; bit 0 selects the add
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic               run_q;
  logic               done_q;

  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        mcand_q  <= {{WIDTH{1'b0}}, A};
        mplier_q <= B;
        acc_q    <= '0;
        cnt_q    <= '0;
        run_q    <= 1'b1;
      end else if (run_q) begin
        if (mplier_q[0]) begin
          acc_q <= acc_q + mcand_q;
        end
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign prod = acc_q;
  assign done = done_q;

endmodule

// File: rtl/calc_alu_seq.sv
// Purpose: calculator execution stage; ADD/SUB/XOR in one cycle, MUL via calc_mul_seq, registered result.
// Latency: valid one cycle after the accepting edge (ADD/SUB/XOR/invalid), WIDTH+1 cycles for MUL.
// Backpressure: start edges arriving while busy are dropped; nothing is queued.
// Ports: CLK, clear_n (async active-low), start, MS[2:0], A, B -> result[2*WIDTH-1:0], valid, busy, err, ovf.
// Option: define CALC_ALU_OVF_EN to register carry/borrow on ovf; otherwise ovf is tied low.
module calc_alu_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               CLK,
  input  logic               clear_n,
  input  logic               start,
  input  logic [2:0]         MS,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] result,
  output logic               valid,
  output logic               busy,
  output logic               err,
  output logic               ovf
);

  alu_state_t         state_q, state_d;
  ms_t                ms_q, ms_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               start_q;  // start delayed by one cycle for edge detection
  logic               armed_q;  // start_q holds a real sample of start

  logic               start_edge;
  logic               mul_load;
  logic [2*WIDTH-1:0] mul_prod;
  logic               mul_done;
  logic [WIDTH-1:0]   add_w;
  logic [WIDTH-1:0]   sub_w;

  // The reset value of start_q is not a sample of start, so a level that is
  // already high when reset releases must not look like a rising edge.
  assign start_edge = start & ~start_q & armed_q;

`ifdef CALC_ALU_OVF_EN
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   sum_w;
  logic             borrow_w;
  assign sum_w    = {1'b0, a_q} + {1'b0, b_q};
  assign add_w    = sum_w[WIDTH-1:0];
  assign borrow_w = (a_q < b_q);
`else
  assign add_w    = a_q + b_q;
`endif
  assign sub_w = a_q - b_q;

  calc_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .CLK     (CLK),
    .clear_n (clear_n),
    .load    (mul_load),
    .A       (A),
    .B       (B),
    .prod    (mul_prod),
    .done    (mul_done)
  );

  always_comb begin
    state_d  = state_q;
    ms_d     = ms_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    err_d    = err_q;
    mul_load = 1'b0;
`ifdef CALC_ALU_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start_edge) begin
          ms_d    = ms_t'(MS);
          a_d     = A;
          b_d     = B;
          valid_d = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
`ifdef CALC_ALU_OVF_EN
          ovf_d   = 1'b0;
`endif
          if (MS == MS_MUL) begin
            // The multiplier captures A/B from the ports on this same edge.
            mul_load = 1'b1;
            state_d  = MUL;
          end else begin
            state_d  = EXEC;
          end
        end
      end
      EXEC: begin
        busy_d  = 1'b0;
        valid_d = 1'b1;
        state_d = DONE;
        case (ms_q)
          MS_ADD: begin
            result_d = {{WIDTH{1'b0}}, add_w};
`ifdef CALC_ALU_OVF_EN
            ovf_d    = sum_w[WIDTH];
`endif
          end
          MS_SUB: begin
            result_d = {{WIDTH{1'b0}}, sub_w};
`ifdef CALC_ALU_OVF_EN
            ovf_d    = borrow_w;
`endif
          end
          MS_XOR: begin
            result_d = {{WIDTH{1'b0}}, a_q ^ b_q};
          end
          default: begin
            result_d = '0;
            err_d    = !ms_is_legal(ms_q) || (ms_q == MS_MUL);
          end
        endcase
      end
      MUL: begin
        if (mul_done) begin
          result_d = mul_prod;
          busy_d   = 1'b0;
          valid_d  = 1'b1;
          state_d  = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= IDLE;
      ms_q     <= MS_NONE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ms_q     <= ms_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      start_q  <= start;
      armed_q  <= 1'b1;
    end
  end

`ifdef CALC_ALU_OVF_EN
  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign result = result_q;
  assign valid  = valid_q;
  assign busy   = busy_q;
  assign err    = err_q;

endmodule

// File: tb/tb_calc_alu_seq.sv
// Bench for calc_alu_seq (WIDTH=4): expected results are queued when an
// operation is accepted and compared when valid rises, including latency.
module tb_calc_alu_seq;

  logic       CLK = 1'b0;
  logic       clear_n;
  logic       start;
  logic [2:0] ms;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] result;
  logic       valid;
  logic       busy;
  logic       err;
  logic       ovf;

  calc_alu_seq #(.WIDTH(4)) dut (
    .CLK     (CLK),
    .clear_n (clear_n),
    .start   (start),
    .MS      (ms),
    .A       (a),
    .B       (b),
    .result  (result),
    .valid   (valid),
    .busy    (busy),
    .err     (err),
    .ovf     (ovf)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] res;
    logic       err;
    logic       ovf;
    int         lat;
    int         due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model of one operation.
  function automatic exp_t model(input logic [2:0] m, input logic [3:0] x, input logic [3:0] y);
    exp_t e;
    logic [4:0] s;
    e.res = 8'h00; e.err = 1'b0; e.ovf = 1'b0; e.lat = 1; e.due = 0;
    s = {1'b0, x} + {1'b0, y};
    case (m)
      3'd1: begin e.res = {4'h0, s[3:0]}; e.ovf = s[4]; end
      3'd2: begin e.res = {4'h0, 4'(x - y)}; e.ovf = (x < y); end
      3'd3: begin e.res = 8'(x * y); e.lat = 5; end
      3'd4: e.res = {4'h0, x ^ y};
      default: e.err = 1'b1;
    endcase
`ifndef CALC_ALU_OVF_EN
    e.ovf = 1'b0;
`endif
    return e;
  endfunction

  // Scoreboard monitor: on each rising valid, pop and compare.
  always @(posedge CLK) begin
    #1;
    if (valid && !prev_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("result", {24'h0, result}, {24'h0, mon_e.res});
        chk("err", {31'h0, err}, {31'h0, mon_e.err});
        chk("ovf", {31'h0, ovf}, {31'h0, mon_e.ovf});
        chk("latency", cyc, mon_e.due);
        chk("busy_at_valid", {31'h0, busy}, 32'd0);
      end
    end
    prev_valid = valid;
  end

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge CLK);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    @(posedge CLK);
    #2;
  endtask

  // Drop start, then raise it with a new op; optionally disturb A/B or add a
  // second start edge while the operation is busy.
  task automatic run_op(input logic [2:0] m, input logic [3:0] x, input logic [3:0] y,
                        input bit toggle, input bit extra_edge);
    exp_t e;
    @(negedge CLK) start = 1'b0;
    @(negedge CLK);
    ms = m; a = x; b = y; start = 1'b1;
    e = model(m, x, y);
    @(posedge CLK);
    #1;
    chk("busy_on_accept", {31'h0, busy}, 32'd1);
    chk("valid_clr_on_accept", {31'h0, valid}, 32'd0);
    e.due = cyc + e.lat;
    sb.push_back(e);
    if (toggle) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge CLK);
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
      end
    end
    if (extra_edge) begin
      @(negedge CLK) start = 1'b0;
      @(negedge CLK);
      ms = 3'd4; a = 4'h5; b = 4'h3; start = 1'b1;
    end
    wait_drain();
  endtask

  initial begin
    clear_n = 1'b0; start = 1'b0; ms = 3'd0; a = 4'h0; b = 4'h0;
    #1;
    chk("rst_result", {24'h0, result}, 32'd0);
    chk("rst_valid", {31'h0, valid}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_err", {31'h0, err}, 32'd0);
    chk("rst_ovf", {31'h0, ovf}, 32'd0);
    repeat (2) @(negedge CLK);
    clear_n = 1'b1;

    run_op(3'd1, 4'd9, 4'd8, 1'b0, 1'b0);     // ADD with carry -> 01
    run_op(3'd2, 4'd3, 4'd5, 1'b0, 1'b0);     // SUB with borrow -> 0E
    run_op(3'd3, 4'd15, 4'd15, 1'b1, 1'b0);   // MUL -> E1, A/B toggled while busy
    run_op(3'd4, 4'hA, 4'h6, 1'b0, 1'b0);     // XOR -> 0C

    // Start held high: no retrigger.
    repeat (20) @(posedge CLK);
    #1;
    chk("hold_valid", {31'h0, valid}, 32'd1);
    chk("hold_busy", {31'h0, busy}, 32'd0);
    chk("hold_result", {24'h0, result}, 32'h0C);

    run_op(3'b110, 4'h7, 4'h2, 1'b0, 1'b0);   // invalid mode
    run_op(3'b000, 4'h1, 4'h1, 1'b0, 1'b0);   // MS_NONE is invalid too
    run_op(3'd3, 4'd13, 4'd11, 1'b0, 1'b1);   // second edge during MUL ignored -> 8F

    // Reset in the middle of a multiply.
    @(negedge CLK) start = 1'b0;
    @(negedge CLK);
    ms = 3'd3; a = 4'd7; b = 4'd5; start = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("busy_before_abort", {31'h0, busy}, 32'd1);
    #2 clear_n = 1'b0;
    #1;
    chk("abort_result", {24'h0, result}, 32'd0);
    chk("abort_valid", {31'h0, valid}, 32'd0);
    chk("abort_busy", {31'h0, busy}, 32'd0);
    chk("abort_err", {31'h0, err}, 32'd0);
    chk("abort_ovf", {31'h0, ovf}, 32'd0);
    @(negedge CLK) clear_n = 1'b1;
    repeat (6) @(posedge CLK);
    #1;
    chk("post_rst_busy", {31'h0, busy}, 32'd0);
    chk("post_rst_valid", {31'h0, valid}, 32'd0);
    run_op(3'd3, 4'd6, 4'd7, 1'b0, 1'b0);     // 42 = 2A

    for (int i = 0; i < 8; i++) begin
      run_op(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 1'b0);
    end
    chk("final_queue_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=done", cyc);
    $fatal(1, "timeout");
  end

endmodule
